// File: rtl/avalon_master_pkg.sv
// Shared types and helpers for the Avalon-MM register initiator.
// No ports: state encoding and counter-width helper only.
package avalon_master_pkg;

  // Bus-side FSM: IDLE = no strobe, ISSUE = one strobe presented on the bus.
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Width needed to count 0..maxpending inclusive.
  function automatic int unsigned cnt_width(input int unsigned maxpending);
    return $clog2(maxpending + 1);
  endfunction

endpackage

// File: rtl/avalon_rsp_fifo.sv
// Synchronous FIFO with a registered head word.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   push, din    - write strobe and data (dropped when full)
//   pop          - consume head word (ignored when empty)
//   dout         - head word, valid while !empty
//   full, empty  - occupancy flags decoded from the count register
module avalon_rsp_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTRWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW     = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTRWIDTH-1:0] wr_ptr;
  logic [PTRWIDTH-1:0] rd_ptr;
  logic [PTRWIDTH-1:0] rd_ptr_nxt;
  logic [CNTW-1:0]     count;
  logic                do_push;
  logic                do_pop;

  assign full       = (count == CNTW'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_nxt = rd_ptr + PTRWIDTH'(1);

  // Storage array; no reset needed, occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, count and the registered head word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTRWIDTH'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      count <= count + CNTW'(do_push) - CNTW'(do_pop);
      // On pop the next head may be the word being written this very cycle.
      if (do_pop) begin
        dout <= (do_push && (wr_ptr == rd_ptr_nxt)) ? din : mem[rd_ptr_nxt];
      end else if (do_push && empty) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/avalon_register_master.sv
// Avalon-MM initiator: converts a valid/ready command stream into single-beat
// pipelined Avalon reads/writes and returns read data in issue order.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   cmd_valid/ready/write/address/data - command stream in
//   rsp_valid/ready/data             - read response stream out
//   avm_read/write/address/writedata - Avalon strobes and fields (registered)
//   avm_waitrequest                  - responder stall
//   avm_readdatavalid/readdata       - pipelined read return
//   pending                          - reads granted whose data is outstanding
module avalon_register_master
  import avalon_master_pkg::*;
#(
  parameter int unsigned BUSWIDTH     = 32,
  parameter int unsigned ADDRESSWIDTH = 8,
  parameter int unsigned MAXPENDING   = 4,
  localparam int unsigned CNTWIDTH    = cnt_width(MAXPENDING)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESSWIDTH-1:0] cmd_address,
  input  logic [BUSWIDTH-1:0]     cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [BUSWIDTH-1:0]     rsp_data,
  output logic                    avm_read,
  output logic                    avm_write,
  output logic [ADDRESSWIDTH-1:0] avm_address,
  output logic [BUSWIDTH-1:0]     avm_writedata,
  input  logic                    avm_waitrequest,
  input  logic                    avm_readdatavalid,
  input  logic [BUSWIDTH-1:0]     avm_readdata,
  output logic [CNTWIDTH-1:0]     pending
);

  state_t              state;
  logic [CNTWIDTH-1:0] credits;
  logic                cmd_accept;
  logic                read_accept;
  logic                rsp_pop;
  logic                read_grant;
  logic                rdv_accept;
  logic                fifo_full;
  logic                fifo_empty;

  // Credits cover reads in flight plus buffered responses, so the FIFO can
  // never overflow; writes bypass the credit check.
  assign cmd_ready   = !reset && ((state == IDLE) || !avm_waitrequest) &&
                       (cmd_write || (credits < CNTWIDTH'(MAXPENDING)));
  assign cmd_accept  = cmd_valid && cmd_ready;
  assign read_accept = cmd_accept && !cmd_write;
  assign rsp_pop     = rsp_valid && rsp_ready;
  assign read_grant  = avm_read && !avm_waitrequest;
  // Return data with nothing outstanding is stale (e.g. after reset).
  assign rdv_accept  = avm_readdatavalid && (pending != '0);
  assign rsp_valid   = !fifo_empty;

  // Bus FSM with registered strobes and fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_accept) begin
            state         <= ISSUE;
            avm_read      <= !cmd_write;
            avm_write     <= cmd_write;
            avm_address   <= cmd_address;
            avm_writedata <= cmd_data;
          end
        end
        ISSUE: begin
          if (!avm_waitrequest) begin
            if (cmd_accept) begin
              avm_read      <= !cmd_write;
              avm_write     <= cmd_write;
              avm_address   <= cmd_address;
              avm_writedata <= cmd_data;
            end else begin
              state     <= IDLE;
              avm_read  <= 1'b0;
              avm_write <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Credit and pending counters; simultaneous inc/dec cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= '0;
      pending <= '0;
    end else begin
      credits <= credits + CNTWIDTH'(read_accept) - CNTWIDTH'(rsp_pop);
      pending <= pending + CNTWIDTH'(read_grant) - CNTWIDTH'(rdv_accept);
    end
  end

  avalon_rsp_fifo #(
    .WIDTH (BUSWIDTH),
    .DEPTH (MAXPENDING)
  ) u_rsp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rdv_accept),
    .din   (avm_readdata),
    .pop   (rsp_pop),
    .dout  (rsp_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(rdv_accept && fifo_full));

  a_credit_bound: assert property (@(posedge clk) disable iff (reset)
    credits <= CNTWIDTH'(MAXPENDING));

  a_hold_on_wait: assert property (@(posedge clk) disable iff (reset)
    ((avm_read || avm_write) && avm_waitrequest) |=>
      $stable({avm_read, avm_write, avm_address, avm_writedata}));

endmodule

// File: tb/tb_avalon_register_master.sv
// Directed bench for avalon_register_master: hand-computed expectations,
// inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_avalon_register_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_address;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        avm_read;
  logic        avm_write;
  logic [7:0]  avm_address;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic [2:0]  pending;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [31:0] rd_vals [4];

  always #5 clk = ~clk;

  avalon_register_master dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_address       (cmd_address),
    .cmd_data          (cmd_data),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_address       (avm_address),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_readdata      (avm_readdata),
    .pending           (pending)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rd_vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_data = '0;
    rsp_ready = 1'b0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;

    // Reset state
    repeat (2) edge_();
    mid();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_avm_read", 64'(avm_read), 64'd0);
    check("rst_avm_write", 64'(avm_write), 64'd0);
    check("rst_avm_address", 64'(avm_address), 64'd0);
    check("rst_avm_writedata", 64'(avm_writedata), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);

    // Single write, no wait
    edge_(); reset = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 8'h04; cmd_data = 32'hDEADBEEF;
    mid();
    check("ready_after_reset", 64'(cmd_ready), 64'd1);
    edge_(); cmd_valid = 1'b0; mid();
    check("wr_strobe", 64'(avm_write), 64'd1);
    check("wr_no_read", 64'(avm_read), 64'd0);
    check("wr_address", 64'(avm_address), 64'h04);
    check("wr_data", 64'(avm_writedata), 64'hDEADBEEF);
    check("wr_ready_next", 64'(cmd_ready), 64'd1);
    edge_(); mid();
    check("wr_one_cycle", 64'(avm_write), 64'd0);

    // Read with three wait cycles
    edge_(); cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 8'h10; avm_waitrequest = 1'b1;
    mid();
    check("rd_idle_ready", 64'(cmd_ready), 64'd1);
    edge_(); cmd_valid = 1'b0; mid();
    check("stall_c1_read", 64'(avm_read), 64'd1);
    check("stall_c1_addr", 64'(avm_address), 64'h10);
    check("stall_c1_ready", 64'(cmd_ready), 64'd0);
    check("stall_c1_pending", 64'(pending), 64'd0);
    for (int i = 2; i <= 3; i++) begin
      edge_(); mid();
      check("stall_read", 64'(avm_read), 64'd1);
      check("stall_addr", 64'(avm_address), 64'h10);
      check("stall_ready", 64'(cmd_ready), 64'd0);
    end
    edge_(); avm_waitrequest = 1'b0; mid();
    check("stall_c4_read", 64'(avm_read), 64'd1);
    check("stall_c4_addr", 64'(avm_address), 64'h10);
    check("stall_c4_pending", 64'(pending), 64'd0);
    edge_(); mid();
    check("granted_read_low", 64'(avm_read), 64'd0);
    check("granted_pending", 64'(pending), 64'd1);
    edge_(); avm_readdatavalid = 1'b1; avm_readdata = 32'hCAFE0010; mid();
    check("rsp_not_yet", 64'(rsp_valid), 64'd0);
    edge_(); avm_readdatavalid = 1'b0; avm_readdata = '0; mid();
    check("rsp_valid_m1", 64'(rsp_valid), 64'd1);
    check("rsp_data_m1", 64'(rsp_data), 64'hCAFE0010);
    check("rsp_pending0", 64'(pending), 64'd0);
    edge_(); rsp_ready = 1'b1; mid();
    edge_(); rsp_ready = 1'b0; mid();
    check("rsp_popped", 64'(rsp_valid), 64'd0);

    // Four back-to-back reads, responses held
    edge_(); cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 8'h20; mid();
    for (int i = 1; i <= 4; i++) begin
      edge_(); cmd_address = 8'(32'h20 + i); mid();
      check("b2b_read", 64'(avm_read), 64'd1);
      check("b2b_addr", 64'(avm_address), 64'(32'h20 + i - 1));
    end
    check("fifth_blocked", 64'(cmd_ready), 64'd0);
    check("b2b_pending3", 64'(pending), 64'd3);
    edge_(); mid();
    check("b2b_idle", 64'(avm_read), 64'd0);
    check("b2b_pending4", 64'(pending), 64'd4);
    for (int i = 0; i < 4; i++) begin
      edge_(); avm_readdatavalid = 1'b1; avm_readdata = rd_vals[i]; mid();
      check("full_ready0", 64'(cmd_ready), 64'd0);
    end
    edge_(); avm_readdatavalid = 1'b0; avm_readdata = '0; mid();
    check("ret_pending0", 64'(pending), 64'd0);
    check("ret_valid", 64'(rsp_valid), 64'd1);
    check("ret_head11", 64'(rsp_data), 64'h11);
    check("ret_ready0", 64'(cmd_ready), 64'd0);
    edge_(); rsp_ready = 1'b1; mid();
    check("pop_cycle_ready0", 64'(cmd_ready), 64'd0);
    edge_(); rsp_ready = 1'b0; mid();
    check("ret_head22", 64'(rsp_data), 64'h22);
    check("fifth_ready", 64'(cmd_ready), 64'd1);
    edge_(); cmd_valid = 1'b0; mid();
    check("fifth_read", 64'(avm_read), 64'd1);
    check("fifth_addr", 64'(avm_address), 64'h24);
    edge_(); mid();
    check("fifth_pending", 64'(pending), 64'd1);
    check("fifth_idle", 64'(avm_read), 64'd0);

    // Credits full, write still passes
    edge_(); cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 8'h30; mid();
    check("credit_full_read", 64'(cmd_ready), 64'd0);
    cmd_write = 1'b1; cmd_data = 32'h12345678; #1;
    check("credit_full_write", 64'(cmd_ready), 64'd1);
    edge_(); cmd_valid = 1'b0; cmd_write = 1'b0; mid();
    check("cf_wr_strobe", 64'(avm_write), 64'd1);
    check("cf_wr_addr", 64'(avm_address), 64'h30);
    check("cf_wr_data", 64'(avm_writedata), 64'h12345678);
    check("cf_wr_noread", 64'(avm_read), 64'd0);
    edge_(); mid();
    check("cf_wr_done", 64'(avm_write), 64'd0);
    check("credits_stay_4", 64'(cmd_ready), 64'd0);

    // Pop and push in the same cycle with two buffered
    edge_(); rsp_ready = 1'b1; mid();
    edge_(); avm_readdatavalid = 1'b1; avm_readdata = 32'h55; mid();
    check("pp_head33", 64'(rsp_data), 64'h33);
    edge_(); rsp_ready = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0; mid();
    check("pp_head44", 64'(rsp_data), 64'h44);
    check("pp_valid", 64'(rsp_valid), 64'd1);
    check("pp_pending0", 64'(pending), 64'd0);
    edge_(); rsp_ready = 1'b1; mid();
    edge_(); mid();
    check("pp_head55", 64'(rsp_data), 64'h55);
    check("pp_valid2", 64'(rsp_valid), 64'd1);
    edge_(); rsp_ready = 1'b0; mid();
    check("pp_drained", 64'(rsp_valid), 64'd0);
    check("pp_credits0", 64'(cmd_ready), 64'd1);

    // Reset with two reads outstanding and a third stalled on the bus
    edge_(); cmd_valid = 1'b1; cmd_address = 8'h40; mid();
    edge_(); cmd_address = 8'h41; mid();
    edge_(); cmd_valid = 1'b0; mid();
    edge_(); mid();
    check("pre_rst_pending2", 64'(pending), 64'd2);
    edge_(); cmd_valid = 1'b1; cmd_address = 8'h42; avm_waitrequest = 1'b1; mid();
    edge_(); cmd_valid = 1'b0; mid();
    check("pre_rst_stalled", 64'(avm_read), 64'd1);
    edge_(); reset = 1'b1; mid();
    check("rst2_cmd_ready", 64'(cmd_ready), 64'd0);
    edge_(); reset = 1'b0; avm_waitrequest = 1'b0; mid();
    check("rst2_read_abort", 64'(avm_read), 64'd0);
    check("rst2_pending", 64'(pending), 64'd0);
    for (int i = 0; i < 2; i++) begin
      edge_(); avm_readdatavalid = 1'b1; avm_readdata = 32'(32'h66 + 32'h11 * i); mid();
      edge_(); avm_readdatavalid = 1'b0; avm_readdata = '0; mid();
      check("stale_rsp_valid", 64'(rsp_valid), 64'd0);
      check("stale_pending", 64'(pending), 64'd0);
    end
    check("post_rst_ready", 64'(cmd_ready), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
